mux_2x1_merge: RTL and testbench
================================

# mux_2x1_merge

Two-to-one stream merger that combines two independent valid/ready input channels into a single registered output channel, using round-robin arbitration when both inputs are valid. It is the gathering counterpart to our 1x2 demux stage: words steered apart upstream are recombined here. A source tag accompanies each output word, and per-source transfer counters are provided for debug readout.

## Interface
- size, 16, data width of every data port
- cnt_width, 8, width of each per-source transfer counter
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- inA  input  size  channel A data
- validA  input  1  channel A word present
- readyA  output  1  channel A word accepted this cycle when high with validA
- inB  input  size  channel B data
- validB  input  1  channel B word present
- readyB  output  1  channel B word accepted this cycle when high with validB
- out1  output  size  merged data (registered)
- out_valid  output  1  out1 holds a word
- out_ready  input  1  downstream accepts out1 this cycle
- out_src  output  1  source of the word in out1: 0 = A, 1 = B (registered)
- countA  output  cnt_width  words accepted from A since reset, wraps
- countB  output  cnt_width  words accepted from B since reset, wraps

## Operation
- Single output register (out1, out_src, out_valid); a transfer occurs on any edge where valid && ready are both high.
- slot_free = !out_valid || out_ready (combinational; register empty or draining this cycle).
- Grant selection when slot_free:
  - only validA -> grant A; only validB -> grant B; neither -> no grant.
  - both valid -> grant the channel not recorded in last_src (internal 1-bit register).
- readyA = slot_free && grant==A; readyB = slot_free && grant==B. The non-granted channel's ready is low. Ready never depends on the same channel's own data.
- On a grant: out1 <= granted data, out_src <= granted id, out_valid <= 1, last_src <= granted id, increment that channel's counter.
- On out_ready && out_valid with no new grant: out_valid <= 0; out1 and out_src hold their last values.
- While out_valid && !out_ready: out1, out_src, out_valid are held unchanged, and readyA = readyB = 0.
- Counters are cnt_width bits, increment by 1 per accepted word, wrap from all-ones to 0 with no flag.
- Reset (synchronous, priority over everything): out1 = 0, out_src = 0, out_valid = 0, countA = countB = 0, last_src = 1 (so A wins the first contested cycle). readyA/readyB follow from out_valid = 0 (i.e. they reflect grant logic in the cycle reset is released). A word held in out1 at reset is discarded. An input handshake in the reset cycle is not counted or stored.

## Timing
- Latency: input accept at edge N -> out_valid high and out1 valid after edge N, usable by downstream at edge N+1.
- Throughput: one word per cycle sustained when out_ready stays high, including back-to-back words from the same channel.
- Contested sustained load with out_ready high: output sequence strictly alternates A, B, A, B...
- readyA/readyB are combinational from out_ready, out_valid, validA, validB, and last_src; there is no combinational path from the data inputs.
- Inputs must hold data/valid until accepted. The block does not require this, but words dropped by an upstream that deasserts early are simply not seen.

## Test plan
- Reset: assert reset 2 cycles with validA = validB = 1 -> out_valid = 0, out1 = 0x0000, out_src = 0, countA = countB = 0; no handshake counted during reset.
- Single A word: inA = 0x1234, validA = 1 for one accepted cycle, out_ready = 1 -> next cycle out1 = 0x1234, out_src = 0, out_valid = 1; countA = 1, countB = 0.
- Contention: validA = validB = 1 continuously, inA = 0xAAAA, inB = 0xBBBB, out_ready = 1 -> out1 alternates 0xAAAA, 0xBBBB, 0xAAAA..., with A first after reset; countA/countB differ by at most 1.
- Backpressure: output holding 0x5555 from B, out_ready = 0 for 4 cycles with both inputs valid -> out1 = 0x5555 and out_src = 1 stable, readyA = readyB = 0; on out_ready = 1, A is granted the same cycle and appears next.
- Counter wrap: 257 accepted B words -> countB = 1, countA unchanged.
- Reset mid-stream: reset asserted while out_valid = 1 and out_ready = 0 -> next cycle out_valid = 0, counters = 0; the first contested grant after release goes to A.

Source files
------------

// File: rtl/mux_2x1_merge_if.sv
// Stream bundle for the 2:1 merger: two valid/ready input channels, one
// registered output channel with source tag, and per-source debug counters.
interface mux_2x1_merge_if #(
  parameter int size      = 16,
  parameter int cnt_width = 8
);
  logic [size-1:0]      inA;
  logic                 validA;
  logic                 readyA;
  logic [size-1:0]      inB;
  logic                 validB;
  logic                 readyB;
  logic [size-1:0]      out1;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_src;
  logic [cnt_width-1:0] countA;
  logic [cnt_width-1:0] countB;

  // Merger side: consumes both input channels, produces the merged channel.
  modport slave (
    input  inA, validA, inB, validB, out_ready,
    output readyA, readyB, out1, out_valid, out_src, countA, countB
  );

  // Environment side: sources both input channels, sinks the merged channel.
  modport master (
    output inA, validA, inB, validB, out_ready,
    input  readyA, readyB, out1, out_valid, out_src, countA, countB
  );
endinterface

// File: rtl/mux_2x1_merge.sv
// Two-to-one stream merger with round-robin arbitration on contention.
// One output register stage; ready is derived only from handshake state,
// never from input data, so there is no data-to-ready combinational path.
module mux_2x1_merge #(
  parameter int size      = 16,
  parameter int cnt_width = 8
) (
  input  logic            clk,
  input  logic            reset,
  mux_2x1_merge_if.slave  bus
);

  logic [size-1:0]      data_p1;
  logic                 src_p1;
  logic                 vld_p1;
  logic                 last_src;
  logic [cnt_width-1:0] cnt_a;
  logic [cnt_width-1:0] cnt_b;

  logic slot_free;
  logic grant_a;
  logic grant_b;

  // The output register can take a word when empty or draining this cycle.
  assign slot_free = !vld_p1 || bus.out_ready;

  // Arbitration: a lone requester wins; on contention the channel that did
  // not win last time is granted (last_src resets to B so A wins first).
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (slot_free) begin
      if (bus.validA && bus.validB) begin
        if (last_src) grant_a = 1'b1;
        else          grant_b = 1'b1;
      end else if (bus.validA) begin
        grant_a = 1'b1;
      end else if (bus.validB) begin
        grant_b = 1'b1;
      end
    end
  end

  assign bus.readyA = grant_a;
  assign bus.readyB = grant_b;

  // ---- stage p1: output register, arbitration history and counters ----
  // Load the granted word, or retire the held word when downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1  <= '0;
      src_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      last_src <= 1'b1;
      cnt_a    <= '0;
      cnt_b    <= '0;
    end else if (grant_a) begin
      data_p1  <= bus.inA;
      src_p1   <= 1'b0;
      vld_p1   <= 1'b1;
      last_src <= 1'b0;
      cnt_a    <= cnt_a + cnt_width'(1);
    end else if (grant_b) begin
      data_p1  <= bus.inB;
      src_p1   <= 1'b1;
      vld_p1   <= 1'b1;
      last_src <= 1'b1;
      cnt_b    <= cnt_b + cnt_width'(1);
    end else if (bus.out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign bus.out1      = data_p1;
  assign bus.out_src   = src_p1;
  assign bus.out_valid = vld_p1;
  assign bus.countA    = cnt_a;
  assign bus.countB    = cnt_b;

endmodule

// File: tb/tb_mux_2x1_merge.sv
// Directed bench for mux_2x1_merge: reset, single word, contention,
// backpressure, counter wrap and reset mid-stream.
module tb_mux_2x1_merge;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mux_2x1_merge_if #(.size(16), .cnt_width(8)) bus ();

  mux_2x1_merge #(.size(16), .cnt_width(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset with both inputs requesting: nothing may be stored or counted.
    reset         = 1'b1;
    bus.inA       = 16'hAAAA;
    bus.inB       = 16'hBBBB;
    bus.validA    = 1'b1;
    bus.validB    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out1",      32'(bus.out1),      32'h0);
    chk("rst_out_src",   32'(bus.out_src),   32'h0);
    chk("rst_countA",    32'(bus.countA),    32'h0);
    chk("rst_countB",    32'(bus.countB),    32'h0);

    // Single A word.
    reset      = 1'b0;
    bus.inA    = 16'h1234;
    bus.validA = 1'b1;
    bus.validB = 1'b0;
    #1;
    chk("single_readyA", 32'(bus.readyA), 32'h1);
    chk("single_readyB", 32'(bus.readyB), 32'h0);
    tick();
    bus.validA = 1'b0;
    chk("single_out1",      32'(bus.out1),      32'h1234);
    chk("single_out_src",   32'(bus.out_src),   32'h0);
    chk("single_out_valid", 32'(bus.out_valid), 32'h1);
    chk("single_countA",    32'(bus.countA),    32'h1);
    chk("single_countB",    32'(bus.countB),    32'h0);
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_out1_hold", 32'(bus.out1),      32'h1234);

    // Fresh reset so contention starts with A.
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    bus.inA    = 16'hAAAA;
    bus.inB    = 16'hBBBB;
    bus.validA = 1'b1;
    bus.validB = 1'b1;
    tick();
    chk("cont1_out1", 32'(bus.out1),    32'hAAAA);
    chk("cont1_src",  32'(bus.out_src), 32'h0);
    tick();
    chk("cont2_out1", 32'(bus.out1),    32'hBBBB);
    chk("cont2_src",  32'(bus.out_src), 32'h1);
    tick();
    chk("cont3_out1", 32'(bus.out1),    32'hAAAA);
    tick();
    chk("cont4_out1", 32'(bus.out1),    32'hBBBB);
    chk("cont_countA", 32'(bus.countA), 32'h2);
    chk("cont_countB", 32'(bus.countB), 32'h2);

    // Load 0x5555 from B alone, then stall the output with both requesting.
    bus.validA = 1'b0;
    bus.inB    = 16'h5555;
    tick();
    chk("bp_load_out1", 32'(bus.out1),    32'h5555);
    chk("bp_load_src",  32'(bus.out_src), 32'h1);
    bus.out_ready = 1'b0;
    bus.validA    = 1'b1;
    bus.validB    = 1'b1;
    #1;
    chk("bp_readyA", 32'(bus.readyA), 32'h0);
    chk("bp_readyB", 32'(bus.readyB), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_out1",  32'(bus.out1),      32'h5555);
      chk("bp_hold_src",   32'(bus.out_src),   32'h1);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_readyA", 32'(bus.readyA),   32'h0);
    end
    chk("bp_countB_stall", 32'(bus.countB), 32'h3);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_readyA", 32'(bus.readyA), 32'h1);
    chk("bp_release_readyB", 32'(bus.readyB), 32'h0);
    tick();
    chk("bp_after_out1", 32'(bus.out1),    32'hAAAA);
    chk("bp_after_src",  32'(bus.out_src), 32'h0);
    chk("bp_after_countA", 32'(bus.countA), 32'h3);

    // Counter wrap: 257 B words from a fresh reset.
    reset      = 1'b1;
    bus.validA = 1'b0;
    bus.validB = 1'b0;
    tick();
    reset      = 1'b0;
    bus.validB = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.inB = 16'(i);
      tick();
      if (i == 254) chk("wrap_countB_ff", 32'(bus.countB), 32'hFF);
    end
    chk("wrap_countB", 32'(bus.countB), 32'h1);
    chk("wrap_countA", 32'(bus.countA), 32'h0);
    chk("wrap_out1",   32'(bus.out1),   32'h0100);

    // Reset while holding a stalled word.
    bus.out_ready = 1'b0;
    bus.inB       = 16'h7777;
    tick();
    chk("mid_pre_valid", 32'(bus.out_valid), 32'h1);
    reset      = 1'b1;
    bus.validA = 1'b1;
    bus.validB = 1'b1;
    bus.inA    = 16'hC0DE;
    tick();
    chk("mid_rst_valid",  32'(bus.out_valid), 32'h0);
    chk("mid_rst_countA", 32'(bus.countA),    32'h0);
    chk("mid_rst_countB", 32'(bus.countB),    32'h0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_readyA", 32'(bus.readyA), 32'h1);
    chk("mid_readyB", 32'(bus.readyB), 32'h0);
    tick();
    chk("mid_first_src",  32'(bus.out_src), 32'h0);
    chk("mid_first_out1", 32'(bus.out1),    32'hC0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
